// File: rtl/f_to_d_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : f_to_d_queue_pkg
//  Description : Shared pipeline constants for the fetch/decode boundary.
//                Holds the NOP encoding and default datapath widths that
//                are reused by the other stage registers.
//  Revision    : 1.0  initial release
// ============================================================================
package f_to_d_queue_pkg;

    // addi r0,r0,0 - bubble injected whenever decode has nothing valid
    localparam logic [31:0] c_nop_inst    = 32'h2000_0000;

    localparam int          c_xlen_dflt   = 32;
    localparam int          c_pc_bits_dflt = 12;
    localparam int          c_depth_dflt  = 4;

endpackage : f_to_d_queue_pkg
`default_nettype wire

// File: rtl/fd_queue_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fd_queue_ram
//  Description : DEPTH x WIDTH storage for the fetch/decode queue.
//                Synchronous write, asynchronous read. Contents are never
//                cleared; the owner masks stale data with its valid flag.
//  Revision    : 1.0  initial release
// ============================================================================
module fd_queue_ram #(
    parameter  int WIDTH = 45,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one entry per cycle when the queue accepts a push
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fd_queue_ram
`default_nettype wire

// File: rtl/f_to_d_queue.sv
`default_nettype none
// ============================================================================
//  Module      : f_to_d_queue
//  Description : DEPTH-entry in-order instruction queue between fetch and
//                decode. Valid/ready handshake on the fetch side, flush on
//                EX redirect, full freeze on MEM_stall. Decode sees a NOP
//                with D_valid=0 whenever the queue is empty.
//  Revision    : 1.0  initial release
// ============================================================================
module f_to_d_queue
    import f_to_d_queue_pkg::*;
#(
    parameter  int XLEN    = c_xlen_dflt,
    parameter  int PC_BITS = c_pc_bits_dflt,
    parameter  int DEPTH   = c_depth_dflt,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    // fetch side
    input  logic               F_valid,
    input  logic [PC_BITS-1:0] F_pc,
    input  logic [XLEN-1:0]    F_inst,
    input  logic               F_BP_taken,
    output logic               F_ready,
    // pipeline control
    input  logic               stall_D,
    input  logic               MEM_stall,
    input  logic               EX_taken,
    // decode side
    output logic               D_valid,
    output logic [PC_BITS-1:0] D_pc,
    output logic [XLEN-1:0]    D_inst,
    output logic               D_BP_taken,
    output logic [CNT_W-1:0]   count
);

    localparam int               c_ptr_w  = $clog2(DEPTH);
    localparam int               c_ent_w  = PC_BITS + XLEN + 1;
    localparam logic [CNT_W-1:0] c_full   = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  c_nop    = XLEN'(c_nop_inst);

    // Pointer wrap relies on DEPTH being a power of two
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("f_to_d_queue: DEPTH must be a power of 2 and >= 2");
    end

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_not_empty;
    logic               w_not_full;
    logic               w_push;
    logic               w_pop;
    logic [c_ent_w-1:0] w_wr_data;
    logic [c_ent_w-1:0] w_rd_data;

    // Ready and valid come only from the registered count, so neither
    // stall input has a combinational path to F_ready.
    assign w_not_empty = (r_count != '0);
    assign w_not_full  = (r_count != c_full);

    // EX redirect kills both directions; MEM_stall freezes both directions
    assign w_push = F_valid & w_not_full & ~MEM_stall & ~EX_taken;
    assign w_pop  = w_not_empty & ~stall_D & ~MEM_stall & ~EX_taken;

    assign w_wr_data = {F_BP_taken, F_pc, F_inst};

    fd_queue_ram #(
        .WIDTH (c_ent_w),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Pointer and occupancy bookkeeping; flush returns to the reset state
    always_ff @(posedge clk) begin
        if (rst || EX_taken) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Head entry is masked so stale storage never leaks to decode
    assign F_ready    = w_not_full;
    assign D_valid    = w_not_empty;
    assign D_inst     = w_not_empty ? w_rd_data[XLEN-1:0]                : c_nop;
    assign D_pc       = w_not_empty ? w_rd_data[XLEN +: PC_BITS]         : '0;
    assign D_BP_taken = w_not_empty ? w_rd_data[c_ent_w-1]               : 1'b0;
    assign count      = r_count;

endmodule : f_to_d_queue
`default_nettype wire

// File: tb/tb_f_to_d_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f_to_d_queue
//  Description : Self-checking bench for f_to_d_queue. Directed scenarios
//                followed by random traffic, all compared against an
//                in-order queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_f_to_d_queue;

    localparam int XLEN    = 32;
    localparam int PC_BITS = 12;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h2000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               F_valid;
    logic [PC_BITS-1:0] F_pc;
    logic [XLEN-1:0]    F_inst;
    logic               F_BP_taken;
    logic               F_ready;
    logic               stall_D;
    logic               MEM_stall;
    logic               EX_taken;
    logic               D_valid;
    logic [PC_BITS-1:0] D_pc;
    logic [XLEN-1:0]    D_inst;
    logic               D_BP_taken;
    logic [CNT_W-1:0]   count;

    always #5 clk = ~clk;

    f_to_d_queue #(
        .XLEN    (XLEN),
        .PC_BITS (PC_BITS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .F_valid    (F_valid),
        .F_pc       (F_pc),
        .F_inst     (F_inst),
        .F_BP_taken (F_BP_taken),
        .F_ready    (F_ready),
        .stall_D    (stall_D),
        .MEM_stall  (MEM_stall),
        .EX_taken   (EX_taken),
        .D_valid    (D_valid),
        .D_pc       (D_pc),
        .D_inst     (D_inst),
        .D_BP_taken (D_BP_taken),
        .count      (count)
    );

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic [XLEN-1:0]    inst;
        logic               bp;
    } ent_t;

    ent_t mq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the model's current queue contents
    task automatic cmp_model();
        bit e;
        e = (mq.size() == 0);
        check("D_valid", 64'(D_valid), 64'(!e));
        check("count",   64'(count),   64'(mq.size()));
        check("F_ready", 64'(F_ready), 64'(mq.size() != DEPTH));
        if (e) begin
            check("D_pc_empty",   64'(D_pc),       64'd0);
            check("D_inst_empty", 64'(D_inst),     64'(NOP));
            check("D_bp_empty",   64'(D_BP_taken), 64'd0);
        end else begin
            check("D_pc",   64'(D_pc),       64'(mq[0].pc));
            check("D_inst", 64'(D_inst),     64'(mq[0].inst));
            check("D_bp",   64'(D_BP_taken), 64'(mq[0].bp));
        end
    endtask

    // One clock: drive inputs, check at negedge, advance model, step clock
    task automatic cyc(input logic r, input logic fv, input logic [PC_BITS-1:0] pc,
                       input logic bp, input logic sd, input logic ms, input logic ex);
        logic [XLEN-1:0] inst;
        bit do_pop, do_push;
        ent_t ent;
        inst       = $urandom;
        rst        = r;
        F_valid    = fv;
        F_pc       = pc;
        F_inst     = inst;
        F_BP_taken = bp;
        stall_D    = sd;
        MEM_stall  = ms;
        EX_taken   = ex;
        @(negedge clk);
        cmp_model();
        if (r || ex) begin
            mq.delete();
        end else begin
            do_push = fv && (mq.size() < DEPTH) && !ms;
            do_pop  = (mq.size() > 0) && !sd && !ms;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                ent.pc   = pc;
                ent.inst = inst;
                ent.bp   = bp;
                mq.push_back(ent);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [PC_BITS-1:0] held_pc;

    initial begin
        rst = 1'b1; F_valid = 1'b0; F_pc = '0; F_inst = '0; F_BP_taken = 1'b0;
        stall_D = 1'b0; MEM_stall = 1'b0; EX_taken = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();

        // 1: reset held for a second cycle
        cyc(1, 1, 12'h3FC, 1, 0, 0, 0);
        check("t1_count",  64'(count),   64'd0);
        check("t1_inst",   64'(D_inst),  64'(NOP));
        check("t1_fready", 64'(F_ready), 64'd1);

        // 2: fill to full under decode stall, fifth push dropped, then drain
        for (int i = 1; i <= 4; i++) cyc(0, 1, 12'(4 * i), 0, 1, 0, 0);
        check("t2_full_count",  64'(count),   64'd4);
        check("t2_full_fready", 64'(F_ready), 64'd0);
        cyc(0, 1, 12'h014, 0, 1, 0, 0);
        check("t2_drop_count", 64'(count), 64'd4);
        check("t2_head",       64'(D_pc),  64'h004);
        for (int i = 2; i <= 4; i++) begin
            cyc(0, 0, 12'h0, 0, 0, 0, 0);
            check("t2_drain_pc", 64'(D_pc), 64'(4 * i));
        end
        cyc(0, 0, 12'h0, 0, 0, 0, 0);
        check("t2_empty", 64'(D_valid), 64'd0);

        // 3: two entries, push+pop every cycle across pointer wrap
        cyc(0, 1, 12'h040, 0, 1, 0, 0);
        cyc(0, 1, 12'h044, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 12'(12'h048 + 4 * i), 0, 0, 0, 0);
            check("t3_count", 64'(count), 64'd2);
            check("t3_pc",    64'(D_pc),  64'(12'h044 + 4 * i));
        end

        // 4: three entries frozen by MEM_stall with fetch pushing
        cyc(0, 1, 12'h0A0, 0, 1, 0, 0);
        held_pc = D_pc;
        for (int i = 0; i < 3; i++) cyc(0, 1, 12'(12'h0B0 + 4 * i), 0, 0, 1, 0);
        check("t4_count", 64'(count), 64'd3);
        check("t4_pc",    64'(D_pc),  64'(held_pc));

        // 5: flush overrides MEM_stall and discards the concurrent push
        cyc(0, 1, 12'h0FF, 1, 0, 1, 1);
        check("t5_count", 64'(count),   64'd0);
        check("t5_valid", 64'(D_valid), 64'd0);
        check("t5_inst",  64'(D_inst),  64'(NOP));
        cyc(0, 1, 12'h100, 0, 1, 0, 0);
        check("t5_push_valid", 64'(D_valid), 64'd1);
        check("t5_push_pc",    64'(D_pc),    64'h100);

        // 6: predicted-taken entry, then reset mid-stream
        cyc(0, 0, 12'h0, 0, 0, 0, 1);
        cyc(0, 1, 12'h020, 1, 1, 0, 0);
        check("t6_pc",    64'(D_pc),       64'h020);
        check("t6_bp",    64'(D_BP_taken), 64'd1);
        check("t6_valid", 64'(D_valid),    64'd1);
        cyc(0, 1, 12'h024, 0, 1, 0, 0);
        cyc(1, 1, 12'h028, 1, 0, 0, 0);
        check("t6_rst_count", 64'(count),   64'd0);
        check("t6_rst_valid", 64'(D_valid), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 9) < 7),
                12'($urandom),
                1'($urandom),
                ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 29) == 0));
        end
        @(negedge clk);
        cmp_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_f_to_d_queue
`default_nettype wire
